// File: rtl/uart_rx_cmd_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_cmd_if
// Description : Bundle of the serial input and the byte/command outputs of the
//               UART command receiver.
//   serial_data_rx : asynchronous serial line, idles high
//   rx_byte/rx_done/frame_err : byte-level results
//   cmd_code/cmd_data/cmd_valid/sum_err : frame-level results
//   master : drives the serial line, observes the results
//   slave  : the receiver itself
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_cmd_if;
  logic       serial_data_rx;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       frame_err;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_data;
  logic       sum_err;

  modport master (
    output serial_data_rx,
    input  rx_byte, rx_done, frame_err, cmd_valid, cmd_code, cmd_data, sum_err
  );

  modport slave (
    input  serial_data_rx,
    output rx_byte, rx_done, frame_err, cmd_valid, cmd_code, cmd_data, sum_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cmd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_cmd
// Description : 8N1 UART receiver followed by a 4-byte command frame parser
//               (header, command, data, checksum). Good frames produce a
//               one-cycle cmd_valid with held cmd_code/cmd_data.
// Ports       :
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - uart_rx_cmd_if.slave: serial_data_rx in; rx_byte, rx_done,
//           frame_err, cmd_valid, cmd_code, cmd_data, sum_err out
// Parameters  : CLK_FREQ (Hz), BAUD (bit/s), HDR (frame header byte).
//               CLK_FREQ/BAUD must lie in 4..65535.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cmd #(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         BAUD     = 9600,
  parameter logic [7:0] HDR      = 8'hAA
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  uart_rx_cmd_if.slave bus
);

  localparam int          c_baud_div  = CLK_FREQ / BAUD;
  localparam logic [15:0] c_half_last = 16'(c_baud_div / 2 - 1);
  localparam logic [15:0] c_bit_last  = 16'(c_baud_div - 1);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    P_HDR = 2'd0,
    P_CMD = 2'd1,
    P_DAT = 2'd2,
    P_SUM = 2'd3
  } p_state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser. Flops reset to the idle (high) line level so that
  // reset release never looks like a start edge. r_rxs_prev gives the
  // previous synchronised value for falling-edge detection.
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_rxs;
  logic r_rxs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_rxs      <= 1'b1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync1    <= bus.serial_data_rx;
      r_rxs      <= r_sync1;
      r_rxs_prev <= r_rxs;
    end
  end

  // --------------------------------------------------------------------------
  // Byte receiver
  // --------------------------------------------------------------------------
  rx_state_t   r_rx_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_byte;
  logic        r_rx_done;
  logic        r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= R_IDLE;
      r_cnt       <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_rx_byte   <= 8'd0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        R_IDLE: begin
          if (!r_rxs && r_rxs_prev) begin
            r_cnt      <= 16'd0;
            r_rx_state <= R_START;
          end
        end
        R_START: begin
          // Mid-start-bit check: a line that is high again was only a glitch.
          if (r_cnt == c_half_last) begin
            if (r_rxs) begin
              r_rx_state <= R_IDLE;
            end else begin
              r_cnt      <= 16'd0;
              r_bit_idx  <= 3'd0;
              r_rx_state <= R_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        R_DATA: begin
          if (r_cnt == c_bit_last) begin
            r_shift   <= {r_rxs, r_shift[7:1]};   // LSB arrives first
            r_cnt     <= 16'd0;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= R_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        R_STOP: begin
          // Returning to idle mid-stop-bit lets a back-to-back start edge in.
          if (r_cnt == c_bit_last) begin
            if (r_rxs) begin
              r_rx_byte <= r_shift;
              r_rx_done <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_rx_state <= R_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame parser: HDR, cmd, data, checksum = (HDR + cmd + data) mod 256.
  // --------------------------------------------------------------------------
  p_state_t   r_p_state;
  logic [7:0] r_cmd;
  logic [7:0] r_data;
  logic [7:0] r_cmd_code;
  logic [7:0] r_cmd_data;
  logic       r_cmd_valid;
  logic       r_sum_err;
  logic [7:0] w_sum;

  assign w_sum = HDR + r_cmd + r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_state   <= P_HDR;
      r_cmd       <= 8'd0;
      r_data      <= 8'd0;
      r_cmd_code  <= 8'd0;
      r_cmd_data  <= 8'd0;
      r_cmd_valid <= 1'b0;
      r_sum_err   <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_sum_err   <= 1'b0;
      if (r_frame_err) begin
        // A corrupted byte invalidates whatever partial frame was collected.
        r_p_state <= P_HDR;
      end else if (r_rx_done) begin
        case (r_p_state)
          P_HDR: begin
            if (r_rx_byte == HDR) begin
              r_p_state <= P_CMD;
            end
          end
          P_CMD: begin
            // No resync on HDR here: a header-valued byte is a legal command.
            r_cmd     <= r_rx_byte;
            r_p_state <= P_DAT;
          end
          P_DAT: begin
            r_data    <= r_rx_byte;
            r_p_state <= P_SUM;
          end
          P_SUM: begin
            if (r_rx_byte == w_sum) begin
              r_cmd_code  <= r_cmd;
              r_cmd_data  <= r_data;
              r_cmd_valid <= 1'b1;
            end else begin
              r_sum_err <= 1'b1;
            end
            r_p_state <= P_HDR;
          end
          default: r_p_state <= P_HDR;
        endcase
      end
    end
  end

  assign bus.rx_byte   = r_rx_byte;
  assign bus.rx_done   = r_rx_done;
  assign bus.frame_err = r_frame_err;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_code  = r_cmd_code;
  assign bus.cmd_data  = r_cmd_data;
  assign bus.sum_err   = r_sum_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cmd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cmd
// Description : Directed self-checking bench for uart_rx_cmd with a 10-cycle
//               bit period. A negedge monitor counts output pulses; stimulus
//               tasks drive the serial line on negedges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cmd;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BAUD_DIV = CLK_FREQ / BAUD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cmd_if bus_if ();

  uart_rx_cmd #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .HDR      (8'hAA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  int   n_rx = 0, n_fe = 0, n_cv = 0, n_se = 0, n_wide = 0, n_both = 0;
  int   last_rx_cyc = 0;
  logic prev_rd = 1'b0, prev_fe = 1'b0, prev_cv = 1'b0, prev_se = 1'b0;

  always @(negedge clk) begin
    if (bus_if.rx_done) begin
      n_rx++;
      last_rx_cyc = cyc;
    end
    if (bus_if.frame_err) n_fe++;
    if (bus_if.cmd_valid) n_cv++;
    if (bus_if.sum_err)   n_se++;
    if ((bus_if.rx_done && prev_rd) || (bus_if.frame_err && prev_fe) ||
        (bus_if.cmd_valid && prev_cv) || (bus_if.sum_err && prev_se)) n_wide++;
    if ((bus_if.rx_done && bus_if.frame_err) || (bus_if.cmd_valid && bus_if.sum_err)) n_both++;
    prev_rd = bus_if.rx_done;
    prev_fe = bus_if.frame_err;
    prev_cv = bus_if.cmd_valid;
    prev_se = bus_if.sum_err;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold_line(input logic v, input int n);
    bus_if.serial_data_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; sends one 8N1 byte with the given stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    fall_cyc = cyc;
    hold_line(1'b0, BAUD_DIV);
    for (int i = 0; i < 8; i++) hold_line(b[i], BAUD_DIV);
    hold_line(stop_bit, BAUD_DIV);
    bus_if.serial_data_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  int b_rx, b_fe, b_cv, b_se;

  task automatic snap();
    b_rx = n_rx; b_fe = n_fe; b_cv = n_cv; b_se = n_se;
  endtask

  initial begin
    bus_if.serial_data_rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_byte",  32'(bus_if.rx_byte), 32'h0);
    check("reset_cmd",      32'({bus_if.cmd_code, bus_if.cmd_data}), 32'h0);
    check("reset_pulses",   32'({bus_if.rx_done, bus_if.frame_err, bus_if.cmd_valid, bus_if.sum_err}), 32'h0);
    rst_n = 1'b1;
    hold_line(1'b1, 5);

    // Single byte with latency measurement: rx_done at pin fall + 2 + 96.
    snap();
    send_byte(8'h5A, 1'b1);
    hold_line(1'b1, 5);
    check("byte_count",     32'(n_rx - b_rx), 32'd1);
    check("byte_value",     32'(bus_if.rx_byte), 32'h5A);
    check("byte_latency",   32'(last_rx_cyc - fall_cyc), 32'd98);
    check("byte_no_fe",     32'(n_fe - b_fe), 32'd0);

    // Good frame, back to back.
    snap();
    send_frame(8'hAA, 8'h01, 8'h37, 8'hE2);
    hold_line(1'b1, 5);
    check("good_rx_count",  32'(n_rx - b_rx), 32'd4);
    check("good_cv_count",  32'(n_cv - b_cv), 32'd1);
    check("good_se_count",  32'(n_se - b_se), 32'd0);
    check("good_cmd_code",  32'(bus_if.cmd_code), 32'h01);
    check("good_cmd_data",  32'(bus_if.cmd_data), 32'h37);

    // Bad checksum (expected 0xBC).
    snap();
    send_frame(8'hAA, 8'h02, 8'h10, 8'h00);
    hold_line(1'b1, 5);
    check("bad_se_count",   32'(n_se - b_se), 32'd1);
    check("bad_cv_count",   32'(n_cv - b_cv), 32'd0);
    check("bad_cmd_held",   32'({bus_if.cmd_code, bus_if.cmd_data}), 32'h0137);

    // Framing error inside a partial frame, then a clean frame.
    snap();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h77, 1'b0);
    hold_line(1'b1, 20);
    send_frame(8'hAA, 8'h03, 8'h04, 8'hB1);
    hold_line(1'b1, 5);
    check("fe_count",       32'(n_fe - b_fe), 32'd1);
    check("fe_rx_count",    32'(n_rx - b_rx), 32'd6);
    check("fe_cv_count",    32'(n_cv - b_cv), 32'd1);
    check("fe_se_count",    32'(n_se - b_se), 32'd0);
    check("fe_cmd",         32'({bus_if.cmd_code, bus_if.cmd_data}), 32'h0304);

    // Short low glitch on an idle line, then a real byte.
    snap();
    hold_line(1'b0, 3);
    hold_line(1'b1, 30);
    check("glitch_no_rx",   32'(n_rx - b_rx), 32'd0);
    check("glitch_no_fe",   32'(n_fe - b_fe), 32'd0);
    send_byte(8'hC3, 1'b1);
    hold_line(1'b1, 5);
    check("after_glitch",   32'(bus_if.rx_byte), 32'hC3);
    check("after_glitch_n", 32'(n_rx - b_rx), 32'd1);

    // Reset during bit 4 of 0xFF.
    snap();
    hold_line(1'b0, BAUD_DIV);
    for (int i = 0; i < 4; i++) hold_line(1'b1, BAUD_DIV);
    hold_line(1'b1, 4);
    rst_n = 1'b0;
    hold_line(1'b1, 2);
    check("midrst_regs",    32'({bus_if.rx_byte, bus_if.cmd_code, bus_if.cmd_data}), 32'h0);
    check("midrst_pulses",  32'({bus_if.rx_done, bus_if.frame_err, bus_if.cmd_valid, bus_if.sum_err}), 32'h0);
    hold_line(1'b1, 2);
    rst_n = 1'b1;
    hold_line(1'b1, 60);
    check("midrst_no_pulse", 32'((n_rx - b_rx) + (n_fe - b_fe) + (n_cv - b_cv) + (n_se - b_se)), 32'd0);
    send_byte(8'h81, 1'b1);
    hold_line(1'b1, 5);
    check("postrst_byte",   32'(bus_if.rx_byte), 32'h81);
    check("postrst_count",  32'(n_rx - b_rx), 32'd1);
    check("postrst_cmd",    32'({bus_if.cmd_code, bus_if.cmd_data}), 32'h0);

    check("pulse_width",    32'(n_wide), 32'd0);
    check("pulse_overlap",  32'(n_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_cmd.md
# uart_rx_cmd

UART receive path for the board-to-host link: deserialises 8N1 bytes from the serial input and assembles them into fixed 4-byte command frames (header, command, data, checksum). Validated commands are presented as a one-cycle strobe with registered code and data. The block is the receiving counterpart of the transmit top and runs in the same clock domain.

## Interface

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s. BAUD_DIV = CLK_FREQ/BAUD (integer division). BAUD_DIV must be at least 4 and at most 65535.
- HDR, 8'hAA: frame header byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- serial_data_rx  in  1  asynchronous serial line; idles high.
- rx_byte  out  8  last correctly framed byte. Held until the next one.
- rx_done  out  1  one-cycle pulse; rx_byte is valid in the same cycle.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled 0.
- cmd_valid  out  1  one-cycle pulse when a frame with a good checksum completes.
- cmd_code  out  8  command byte of the last good frame. Held.
- cmd_data  out  8  data byte of the last good frame. Held.
- sum_err  out  1  one-cycle pulse when a frame completes with a bad checksum.

## Operation

- Input conditioning:
  - serial_data_rx passes through a 2-flop synchroniser; both flops reset to 1.
  - All logic below uses the synchronised signal `rxs`.
- Byte receiver FSM, states R_IDLE, R_START, R_DATA, R_STOP:
  - R_IDLE: when `rxs` is 0 and its previous value was 1 (falling edge), clear the 16-bit baud counter and go to R_START.
  - R_START: at count BAUD_DIV/2-1, sample `rxs`.
    - If 1, the low pulse was a glitch: return to R_IDLE with no pulse of any kind.
    - If 0, clear the counter and the bit index, then go to R_DATA.
  - R_DATA: at each count of BAUD_DIV-1, shift `rxs` in LSB first. After bit index 7, go to R_STOP.
  - R_STOP: at count BAUD_DIV-1, sample the stop bit.
    - If 1: load rx_byte and pulse rx_done.
    - If 0: pulse frame_err; rx_byte is unchanged.
    - In both cases return to R_IDLE.
  - Parity is not supported.
- Frame parser FSM, states P_HDR, P_CMD, P_DAT, P_SUM. It advances only on rx_done.
  - P_HDR: a byte equal to HDR goes to P_CMD. Any other byte is discarded and the parser stays in P_HDR.
  - P_CMD: latch the byte into an internal cmd register, go to P_DAT. A byte equal to HDR is accepted as a command here; there is no resync.
  - P_DAT: latch the byte into an internal data register, go to P_SUM.
  - P_SUM: the expected checksum is (HDR + cmd + data) mod 256, truncated to 8 bits.
    - On a match: load cmd_code and cmd_data, pulse cmd_valid.
    - On a mismatch: pulse sum_err; cmd_code and cmd_data are unchanged.
    - In both cases go to P_HDR.
  - frame_err in any parser state forces P_HDR and discards the partial frame.
- Reset values:
  - All outputs are 0.
  - Both FSMs are in their IDLE/HDR states.
  - The synchroniser holds 1.

## Timing

- Let t0 be the first cycle in which `rxs` is 0 while in R_IDLE (2 cycles after the pin falls).
  - Start bit check at t0 + BAUD_DIV/2.
  - Data bit i sampled at t0 + BAUD_DIV/2 + (i+1)·BAUD_DIV.
  - Stop bit sampled at t0 + BAUD_DIV/2 + 9·BAUD_DIV.
- rx_done or frame_err is registered and goes high the cycle after the stop sample.
- cmd_valid or sum_err goes high the cycle after the rx_done of the checksum byte.
- All pulse outputs are exactly one cycle wide.
- rx_done and frame_err are never high in the same cycle. cmd_valid and sum_err are never high in the same cycle.
- The receiver is in R_IDLE one cycle after the stop sample, so a start edge during the second half of the stop bit is accepted (back-to-back bytes).
- rst_n low at any point, including mid-byte or mid-frame, clears everything immediately with no pulses. The first falling edge after release starts a new byte.

## Test plan

Test configuration: CLK_FREQ=1_000_000, BAUD=100_000, so BAUD_DIV=10.

- Byte 0x5A sent at 10-cycle bit period -> rx_done one cycle wide at t0+96, rx_byte=0x5A, frame_err stays 0.
- Frame AA 01 37 E2 sent back-to-back -> four rx_done pulses, then cmd_valid one cycle with cmd_code=0x01 and cmd_data=0x37; sum_err stays 0.
- After the previous frame, send AA 02 10 00 (bad checksum) -> sum_err one cycle, no cmd_valid, cmd_code stays 0x01 and cmd_data stays 0x37.
- Send AA 05, then a byte with stop bit 0, then frame AA 03 04 B1 -> frame_err one cycle, partial frame discarded, then cmd_valid with cmd_code=0x03 and cmd_data=0x04.
- 3-cycle low glitch on an idle line -> no rx_done and no frame_err. A byte 0xC3 that follows is received correctly.
- rst_n pulsed low during bit 4 of byte 0xFF -> all outputs 0 during reset, no pulses. Byte 0x81 sent after release gives rx_byte=0x81.
